// File: rtl/bool_truth_table_extractor.sv
// Sweeps every input vector into a combinational function under test and publishes its truth table.
// Optional compare against an expected mask when built with TT_COMPARE_EN defined.
module bool_truth_table_extractor #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   minterm_mask,
  output logic [N_IN:0]        ones_count
`ifdef TT_COMPARE_EN
  ,
  input  logic [2**N_IN-1:0]   expected_mask,
  output logic                 mismatch
`endif
);

  localparam int              LP_NV       = 2**N_IN;
  localparam logic            LP_SKIP     = (SETTLE == 0);
  localparam logic [3:0]      LP_CNT_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_IN-1:0] LP_VEC_MAX  = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [N_IN-1:0]   r_vec;
  logic [3:0]        r_cnt;
  logic [LP_NV-1:0]  r_shadow;
  logic [LP_NV-1:0]  r_mask;
  logic [N_IN:0]     r_ones;
  logic              r_busy;
  logic              r_done;
  logic [LP_NV-1:0]  w_final;
  logic [N_IN:0]     w_pop;
  logic              w_last_vec;
  logic              w_hold_end;

  assign w_last_vec = (r_vec == LP_VEC_MAX);
  assign w_hold_end = (r_cnt == LP_CNT_LAST);

  // Shadow with the bit being sampled this cycle folded in, so the last vector is published too.
  always_comb begin
    w_final        = r_shadow;
    w_final[r_vec] = f_in;
    w_pop          = '0;
    for (int i = 0; i < LP_NV; i++) begin
      w_pop = w_pop + {{N_IN{1'b0}}, w_final[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = LP_SKIP ? S_SAMPLE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_hold_end) begin
          w_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (w_last_vec) begin
          w_next = S_IDLE;
        end else begin
          w_next = LP_SKIP ? S_SAMPLE : S_HOLD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_mask   <= '0;
      r_ones   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_HOLD: begin
          r_cnt <= r_cnt + 4'd1;
        end
        S_SAMPLE: begin
          r_shadow <= w_final;
          r_cnt    <= '0;
          if (w_last_vec) begin
            r_mask <= w_final;
            r_ones <= w_pop;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_vec <= r_vec + N_IN'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TT_COMPARE_EN
  logic r_mismatch;

  // expected_mask only matters on the publishing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
    end else if (r_state == S_SAMPLE && w_last_vec) begin
      r_mismatch <= (w_final != expected_mask);
    end
  end

  assign mismatch = r_mismatch;
`endif

  assign vec          = r_vec;
  assign busy         = r_busy;
  assign done         = r_done;
  assign minterm_mask = r_mask;
  assign ones_count   = r_ones;

endmodule

// File: tb/tb_bool_truth_table_extractor.sv
// Directed bench for bool_truth_table_extractor: SETTLE=1 main instance plus a SETTLE=0 instance.
module tb_bool_truth_table_extractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  logic [1:0] fut_sel = 2'd0;
  logic [2:0] vec, vec0;
  logic       f_in, f_in0;
  logic       busy, done, busy0, done0;
  logic [7:0] mask, mask0;
  logic [3:0] ones, ones0;
`ifdef TT_COMPARE_EN
  logic [7:0] exp_mask = 8'h5A;
  logic       mism, mism0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // (A|B|C)&(A|~B|C)&(~A|B|~C)&(~A|~B|~C), vec = {A,B,C}
  function automatic logic fut(input logic [2:0] v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    return (a | b | c) & (a | ~b | c) & (~a | b | ~c) & (~a | ~b | ~c);
  endfunction

  assign f_in  = (fut_sel == 2'd0) ? fut(vec) : (fut_sel == 2'd1);
  assign f_in0 = fut(vec0);

  always #5 clk = ~clk;

  bool_truth_table_extractor #(.N_IN(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .f_in(f_in),
    .busy(busy), .done(done), .minterm_mask(mask), .ones_count(ones)
`ifdef TT_COMPARE_EN
    , .expected_mask(exp_mask), .mismatch(mism)
`endif
  );

  bool_truth_table_extractor #(.N_IN(3), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec(vec0), .f_in(f_in0),
    .busy(busy0), .done(done0), .minterm_mask(mask0), .ones_count(ones0)
`ifdef TT_COMPARE_EN
    , .expected_mask(exp_mask), .mismatch(mism0)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sits 1 time unit after a rising edge. Returns just after the done edge.
  task automatic sweep(input string tag, input logic [7:0] exp_m, input logic [3:0] exp_o,
                       input logic [7:0] prev_m, input bit chk_vec, input bit poke);
    int cyc;
    bit hold_ok;
    bit vec_ok;
    hold_ok = 1'b1;
    vec_ok  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_vec0"}, 32'(vec), 32'd0);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (mask !== prev_m) hold_ok = 1'b0;
      if (chk_vec && vec !== 3'(cyc / 2)) vec_ok = 1'b0;
      start = poke && (cyc == 6);
      step();
      cyc++;
    end
    start = 1'b0;
    check_eq({tag, "_cycles"}, 32'(cyc), 32'd16);
    check_eq({tag, "_mask_stable"}, 32'(hold_ok), 32'd1);
    if (chk_vec) check_eq({tag, "_vec_hold"}, 32'(vec_ok), 32'd1);
    check_eq({tag, "_mask"}, 32'(mask), 32'(exp_m));
    check_eq({tag, "_ones"}, 32'(ones), 32'(exp_o));
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_vec_last"}, 32'(vec), 32'd7);
  endtask

  initial begin
    int dcnt;
    int cyc;
    #2;
    check_eq("rst_vec", 32'(vec), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_mask", 32'(mask), 32'd0);
    check_eq("rst_ones", 32'(ones), 32'd0);
`ifdef TT_COMPARE_EN
    check_eq("rst_mism", 32'(mism), 32'd0);
`endif
    step();
    step();
    rst = 1'b0;

    dcnt = 0;
    repeat (50) begin
      step();
      if (done || busy) dcnt++;
    end
    check_eq("idle_no_done", 32'(dcnt), 32'd0);

    // SETTLE=0 instance: one cycle per vector
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 100) begin
      step();
      cyc++;
    end
    check_eq("s0_cycles", 32'(cyc), 32'd8);
    check_eq("s0_mask", 32'(mask0), 32'h5A);
    check_eq("s0_ones", 32'(ones0), 32'd4);
`ifdef TT_COMPARE_EN
    check_eq("s0_mism", 32'(mism0), 32'd0);
`endif

    fut_sel = 2'd0;
    sweep("fut", 8'h5A, 4'd4, 8'h00, 1'b1, 1'b0);
`ifdef TT_COMPARE_EN
    check_eq("fut_mism", 32'(mism), 32'd0);
`endif
    step();
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("mask_after", 32'(mask), 32'h5A);
    check_eq("vec_after", 32'(vec), 32'd7);

    // asynchronous reset mid-clock clears published results
    #3 rst = 1'b1;
    #1;
    check_eq("arst_mask", 32'(mask), 32'd0);
    check_eq("arst_ones", 32'(ones), 32'd0);
    check_eq("arst_vec", 32'(vec), 32'd0);
    rst = 1'b0;
    step();

    fut_sel = 2'd1;
    sweep("one", 8'hFF, 4'd8, 8'h00, 1'b0, 1'b0);
`ifdef TT_COMPARE_EN
    check_eq("one_mism", 32'(mism), 32'd1);
`endif
    fut_sel = 2'd2;
    sweep("zero", 8'h00, 4'd0, 8'hFF, 1'b0, 1'b0);

    fut_sel = 2'd0;
    sweep("poke", 8'h5A, 4'd4, 8'h00, 1'b1, 1'b1);
`ifdef TT_COMPARE_EN
    exp_mask = 8'h5B;
`endif
    sweep("b2b", 8'h5A, 4'd4, 8'h5A, 1'b1, 1'b0);
`ifdef TT_COMPARE_EN
    check_eq("b2b_mism", 32'(mism), 32'd1);
    exp_mask = 8'h5A;
`endif

    // reset aborts a sweep at vec=5 with no partial publication
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check_eq("abort_vec5", 32'(vec), 32'd5);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_mask", 32'(mask), 32'd0);
    check_eq("abort_ones", 32'(ones), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_vec", 32'(vec), 32'd0);
    rst = 1'b0;
    step();
    dcnt = 0;
    repeat (30) begin
      step();
      if (done) dcnt++;
    end
    check_eq("abort_no_done", 32'(dcnt), 32'd0);
    sweep("post", 8'h5A, 4'd4, 8'h00, 1'b1, 1'b0);
`ifdef TT_COMPARE_EN
    check_eq("post_mism", 32'(mism), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
